// File: rtl/fir_mac_seq.sv
// Sequential FIR driving an external MAC16 one tap per cycle: accept -> result valid TAPS+1 edges later.
// Accepts a sample only when idle; result held until M_READY; FIR_SAT_EN selects saturating output.
module fir_mac_seq #(
   parameter int TAPS  = 8,
   parameter int SHIFT = 15
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [15:0]               s_data,
   input  logic                      s_valid,
   output logic                      s_ready,
   output logic [15:0]               m_data,
   output logic                      m_valid,
   input  logic                      m_ready,
   input  logic                      coef_we,
   input  logic [$clog2(TAPS)-1:0]   coef_addr,
   input  logic [15:0]               coef_data,
   output logic [15:0]               mac_a,
   output logic [15:0]               mac_b,
   output logic                      mac_lda,
   output logic                      mac_hld,
   input  logic [31:0]               mac_o
);

   localparam int AW = $clog2(TAPS);
   localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   k_q, k_d;
   logic [AW-1:0]   wptr_q, wptr_d;
   logic [AW-1:0]   base_q, base_d;
   logic [AW-1:0]   rd_idx;
   logic [15:0]     x_q [TAPS];
   logic [15:0]     x_d [TAPS];
   logic [15:0]     h_q [TAPS];
   logic [15:0]     h_d [TAPS];
   logic            m_valid_q, m_valid_d;
   logic [15:0]     m_data_q, m_data_d;
   logic [15:0]     mac_a_q, mac_a_d;
   logic [15:0]     mac_b_q, mac_b_d;
   logic            mac_lda_q, mac_lda_d;
   logic            mac_hld_q, mac_hld_d;
   logic            s_ready_q, s_ready_d;

   logic signed [31:0] shifted;
   logic [15:0]        out_res;
   logic               fmt_unused;

   assign shifted    = $signed(mac_o) >>> SHIFT;
   assign fmt_unused = ^{mac_o, shifted};

`ifdef FIR_SAT_EN
   localparam logic signed [31:0] POS_MAX = 32'sh0000_7FFF;
   localparam logic signed [31:0] NEG_MIN = -32'sh0000_8000;

   always_comb begin
      if (shifted > POS_MAX)
         out_res = 16'h7FFF;
      else if (shifted < NEG_MIN)
         out_res = 16'h8000;
      else
         out_res = shifted[15:0];
   end
`else
   always_comb begin
      out_res = shifted[15:0];
   end
`endif

   // MAC operands are registered one step ahead so the MAC sees tap k while k_q==k
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      wptr_d    = wptr_q;
      base_d    = base_q;
      x_d       = x_q;
      h_d       = h_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      mac_a_d   = '0;
      mac_b_d   = '0;
      mac_lda_d = 1'b0;
      mac_hld_d = 1'b1;
      rd_idx    = '0;

      case (state_q)
         IDLE: begin
            if (coef_we)
               h_d[coef_addr] = coef_data;
            if (s_valid) begin
               x_d[wptr_q] = s_data;
               base_d      = wptr_q;
               wptr_d      = wptr_q + AW'(1);
               k_d         = '0;
               state_d     = RUN;
               mac_a_d     = s_data;
               mac_b_d     = h_d[0];
               mac_lda_d   = 1'b1;
               mac_hld_d   = 1'b0;
            end
         end
         RUN: begin
            if (k_q == K_LAST) begin
               k_d     = '0;
               state_d = DRAIN;
            end else begin
               k_d       = k_q + AW'(1);
               rd_idx    = base_q - k_d;
               mac_a_d   = x_q[rd_idx];
               mac_b_d   = h_q[k_d];
               mac_hld_d = 1'b0;
            end
         end
         DRAIN: begin
            state_d   = OUT;
            m_valid_d = 1'b1;
            m_data_d  = out_res;
         end
         OUT: begin
            if (m_ready) begin
               state_d   = IDLE;
               m_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      s_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         k_q       <= '0;
         wptr_q    <= '0;
         base_q    <= '0;
         for (int i = 0; i < TAPS; i++) begin
            x_q[i] <= '0;
            h_q[i] <= '0;
         end
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         mac_a_q   <= '0;
         mac_b_q   <= '0;
         mac_lda_q <= 1'b0;
         mac_hld_q <= 1'b1;
         s_ready_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         wptr_q    <= wptr_d;
         base_q    <= base_d;
         x_q       <= x_d;
         h_q       <= h_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         mac_a_q   <= mac_a_d;
         mac_b_q   <= mac_b_d;
         mac_lda_q <= mac_lda_d;
         mac_hld_q <= mac_hld_d;
         s_ready_q <= s_ready_d;
      end
   end

   assign s_ready = s_ready_q;
   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign mac_a   = mac_a_q;
   assign mac_b   = mac_b_q;
   assign mac_lda = mac_lda_q;
   assign mac_hld = mac_hld_q;

endmodule
